// File: rtl/bsg_round_robin_arb_burst.sv
// Round-robin arbiter with burst hold-off and optional grant lock.
// Define BSG_RR_ARB_STARVE_CHK_EN to build the per-requester starvation monitor.
module bsg_round_robin_arb_burst #(
  parameter int inputs_p        = 32,
  parameter int lg_inputs_lp    = $clog2(inputs_p),
  parameter int burst_max_p     = 1,
  parameter int hold_on_valid_p = 1,
  parameter int starve_limit_p  = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    grants_en_i,
  input  logic [inputs_p-1:0]     reqs_i,
  output logic [inputs_p-1:0]     grants_o,
  output logic [inputs_p-1:0]     sel_one_hot_o,
  output logic                    v_o,
  output logic [lg_inputs_lp-1:0] tag_o,
  input  logic                    yumi_i,
  output logic                    starve_o
);

  localparam int cnt_w_lp = $clog2(burst_max_p + 1);
  localparam int iw_lp    = lg_inputs_lp + 1;

  logic [lg_inputs_lp-1:0] prio_r;
  logic [lg_inputs_lp-1:0] lock_idx_r;
  logic [cnt_w_lp-1:0]     cnt_r;
  logic                    lock_v_r;

  logic [lg_inputs_lp-1:0] scan_idx;
  logic [lg_inputs_lp-1:0] win_idx;
  logic [lg_inputs_lp-1:0] next_prio;
  logic [iw_lp-1:0]        cand;
  logic [cnt_w_lp:0]       n_cnt;
  logic                    lock_hit;
  logic                    accept;
  logic                    rotate;

  // Scan downward so the closest requester at or after prio_r wins last.
  always_comb begin
    scan_idx = prio_r;
    cand     = '0;
    for (int k = inputs_p - 1; k >= 0; k--) begin
      cand = {1'b0, prio_r} + iw_lp'(k);
      if (cand >= iw_lp'(inputs_p))
        cand = cand - iw_lp'(inputs_p);
      if (reqs_i[cand[lg_inputs_lp-1:0]])
        scan_idx = cand[lg_inputs_lp-1:0];
    end
  end

  assign lock_hit = lock_v_r & reqs_i[lock_idx_r];
  assign win_idx  = lock_hit ? lock_idx_r : scan_idx;

  assign v_o      = ~reset_i & (|reqs_i);
  assign tag_o    = v_o ? win_idx : '0;
  assign sel_one_hot_o = v_o
    ? ({{(inputs_p-1){1'b0}}, 1'b1} << win_idx)
    : '0;
  assign grants_o = sel_one_hot_o & {inputs_p{grants_en_i}};

  assign accept = yumi_i & v_o & grants_en_i;

  always_comb begin
    n_cnt = (cnt_w_lp+1)'(1);
    if (win_idx == prio_r)
      n_cnt = {1'b0, cnt_r} + (cnt_w_lp+1)'(1);
  end

  assign rotate    = n_cnt == (cnt_w_lp+1)'(burst_max_p);
  assign next_prio = (win_idx == lg_inputs_lp'(inputs_p - 1))
    ? '0
    : win_idx + lg_inputs_lp'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_r <= '0;
      cnt_r  <= '0;
    end else if (accept) begin
      if (rotate) begin
        prio_r <= next_prio;
        cnt_r  <= '0;
      end else begin
        prio_r <= win_idx;
        cnt_r  <= n_cnt[cnt_w_lp-1:0];
      end
    end
  end

  // A grant offered but not taken is pinned until accepted or withdrawn.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_v_r   <= 1'b0;
      lock_idx_r <= '0;
    end else if (hold_on_valid_p != 0) begin
      if (accept) begin
        lock_v_r <= 1'b0;
      end else if (v_o & grants_en_i & ~yumi_i) begin
        lock_v_r   <= 1'b1;
        lock_idx_r <= win_idx;
      end else if (~reqs_i[lock_idx_r]) begin
        lock_v_r <= 1'b0;
      end
    end
  end

`ifdef BSG_RR_ARB_STARVE_CHK_EN
  localparam int sw_lp = $clog2(starve_limit_p + 1);

  logic [inputs_p-1:0][sw_lp-1:0] wait_r;
  logic                           starve_r;
  logic                           starve_any;

  always_comb begin
    starve_any = 1'b0;
    for (int i = 0; i < inputs_p; i++)
      if (wait_r[i] >= sw_lp'(starve_limit_p))
        starve_any = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_r   <= '0;
      starve_r <= 1'b0;
    end else begin
      for (int i = 0; i < inputs_p; i++) begin
        if (~reqs_i[i] | (accept & (win_idx == lg_inputs_lp'(i))))
          wait_r[i] <= '0;
        else if (wait_r[i] != sw_lp'(starve_limit_p))
          wait_r[i] <= wait_r[i] + sw_lp'(1);
      end
      starve_r <= starve_any;
    end
  end

  assign starve_o = starve_r & ~reset_i;
`else
  assign starve_o = 1'b0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    assert (reset_i || !yumi_i || (v_o && grants_en_i))
      else $warning("yumi_i ignored: no enabled grant offered");
  end
`endif

endmodule

// File: tb/tb_bsg_round_robin_arb_burst.sv
// Bench for bsg_round_robin_arb_burst: vector table, corner sequences,
// randomized run against a behavioural arbiter model.
module tb_bsg_round_robin_arb_burst;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          yumi;
  logic [N-1:0]  reqs;

  logic [N-1:0]  a_gnt, a_sel, b_gnt, b_sel, c_gnt, c_sel;
  logic [4:0]    a_tag, b_tag, c_tag;
  logic          a_v, b_v, c_v, a_st, b_st, c_st;

  always #5 clk = ~clk;

  bsg_round_robin_arb_burst #(.inputs_p(N)) dut_a (
    .clk_i(clk), .reset_i(reset), .grants_en_i(en), .reqs_i(reqs),
    .grants_o(a_gnt), .sel_one_hot_o(a_sel), .v_o(a_v), .tag_o(a_tag),
    .yumi_i(yumi), .starve_o(a_st));

  bsg_round_robin_arb_burst #(
    .inputs_p(N), .burst_max_p(2), .hold_on_valid_p(0)
  ) dut_b (
    .clk_i(clk), .reset_i(reset), .grants_en_i(en), .reqs_i(reqs),
    .grants_o(b_gnt), .sel_one_hot_o(b_sel), .v_o(b_v), .tag_o(b_tag),
    .yumi_i(yumi), .starve_o(b_st));

  bsg_round_robin_arb_burst #(
    .inputs_p(N), .burst_max_p(8), .starve_limit_p(4)
  ) dut_c (
    .clk_i(clk), .reset_i(reset), .grants_en_i(en), .reqs_i(reqs),
    .grants_o(c_gnt), .sel_one_hot_o(c_sel), .v_o(c_v), .tag_o(c_tag),
    .yumi_i(yumi), .starve_o(c_st));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle's inputs; returns at the falling edge for sampling.
  task automatic drive(input logic r, input logic [31:0] q,
                       input logic e, input logic y);
    reset = r; reqs = q; en = e; yumi = y;
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    next_edge();
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    next_edge();
  endtask

  // Behavioural model: priority index, burst count and lock per config.
  int m_prio[2], m_cnt[2], m_li[2];
  bit m_lv[2];
  int m_burst[2] = '{1, 2};
  bit m_hold[2]  = '{1'b1, 1'b0};

  function automatic int m_win(int m, logic [31:0] q);
    if (m_hold[m] && m_lv[m] && q[m_li[m]]) return m_li[m];
    for (int k = 0; k < N; k++)
      if (q[(m_prio[m] + k) % N]) return (m_prio[m] + k) % N;
    return 0;
  endfunction

  function automatic void m_reset();
    for (int m = 0; m < 2; m++) begin
      m_prio[m] = 0; m_cnt[m] = 0; m_lv[m] = 0; m_li[m] = 0;
    end
  endfunction

  function automatic void m_step(int m, logic r, logic [31:0] q,
                                 logic e, logic y);
    int w, n;
    bit v, acc;
    if (r) begin
      m_prio[m] = 0; m_cnt[m] = 0; m_lv[m] = 0;
      return;
    end
    v   = (q != 0);
    w   = m_win(m, q);
    acc = y && v && e;
    if (acc) begin
      n = (w == m_prio[m]) ? m_cnt[m] + 1 : 1;
      if (n == m_burst[m]) begin
        m_prio[m] = (w + 1) % N; m_cnt[m] = 0;
      end else begin
        m_prio[m] = w; m_cnt[m] = n;
      end
    end
    if (m_hold[m]) begin
      if (acc) m_lv[m] = 0;
      else if (v && e && !y) begin m_lv[m] = 1; m_li[m] = w; end
      else if (!q[m_li[m]]) m_lv[m] = 0;
    end
  endfunction

  typedef struct {
    logic [31:0] reqs;
    logic        en;
    logic        yumi;
    logic        v;
    logic [4:0]  tag;
    logic [31:0] sel;
    logic [31:0] gnt;
  } vec_t;

  vec_t tbl[15];
  int   exp4[6] = '{0, 0, 1, 1, 0, 0};

  initial begin
    logic [31:0] one;
    logic [31:0] q, es;
    logic        r, e, y;
    int          w;
    one = 32'd1;

    tbl[0]  = '{32'h0000_0000, 1, 0, 0, 0,  32'h0,         32'h0};
    tbl[1]  = '{32'h8000_0001, 1, 0, 1, 0,  32'h1,         32'h1};
    tbl[2]  = '{32'h8000_0001, 1, 1, 1, 0,  32'h1,         32'h1};
    tbl[3]  = '{32'h8000_0001, 1, 1, 1, 31, 32'h8000_0000, 32'h8000_0000};
    tbl[4]  = '{32'h8000_0001, 1, 1, 1, 0,  32'h1,         32'h1};
    tbl[5]  = '{32'h8000_0001, 1, 1, 1, 31, 32'h8000_0000, 32'h8000_0000};
    tbl[6]  = '{32'h0000_0010, 0, 1, 1, 4,  32'h10,        32'h0};
    tbl[7]  = '{32'h0000_0024, 1, 0, 1, 2,  32'h4,         32'h4};
    tbl[8]  = '{32'h0000_0005, 1, 0, 1, 2,  32'h4,         32'h4};
    tbl[9]  = '{32'h0000_0005, 1, 1, 1, 2,  32'h4,         32'h4};
    tbl[10] = '{32'h0000_0005, 1, 0, 1, 0,  32'h1,         32'h1};
    tbl[11] = '{32'h0000_0004, 1, 0, 1, 2,  32'h4,         32'h4};
    tbl[12] = '{32'h0000_0000, 1, 1, 0, 0,  32'h0,         32'h0};
    tbl[13] = '{32'h0000_0008, 1, 1, 1, 3,  32'h8,         32'h8};
    tbl[14] = '{32'h0000_0018, 1, 0, 1, 4,  32'h10,        32'h10};

    reset = 1'b1; reqs = '0; en = 1'b0; yumi = 1'b0;

    // Outputs held low while in reset, even with requests present.
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("reset v_o", 32'(a_v), 32'h0);
    check("reset tag_o", 32'(a_tag), 32'h0);
    check("reset grants_o", a_gnt, 32'h0);
    check("reset sel_one_hot_o", a_sel, 32'h0);
    next_edge();
    do_reset();

    for (int i = 0; i < 15; i++) begin
      drive(1'b0, tbl[i].reqs, tbl[i].en, tbl[i].yumi);
      check($sformatf("vec%0d v_o", i), 32'(a_v), 32'(tbl[i].v));
      check($sformatf("vec%0d tag_o", i), 32'(a_tag), 32'(tbl[i].tag));
      check($sformatf("vec%0d sel", i), a_sel, tbl[i].sel);
      check($sformatf("vec%0d grants", i), a_gnt, tbl[i].gnt);
      next_edge();
    end

    // Burst of two per winner, wrapping past prio_r.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h3, 1'b1, 1'b1);
      check($sformatf("burst2 tag%0d", i), 32'(b_tag), 32'(exp4[i]));
      next_edge();
    end

    // Reset mid-handshake drops lock and pointer.
    do_reset();
    drive(1'b0, 32'h8000_0001, 1'b1, 1'b1);
    next_edge();
    drive(1'b0, 32'h8000_0001, 1'b1, 1'b0);
    check("midrst pre tag", 32'(a_tag), 32'd31);
    next_edge();
    drive(1'b1, 32'h8000_0001, 1'b1, 1'b1);
    check("midrst v_o", 32'(a_v), 32'h0);
    check("midrst grants", a_gnt, 32'h0);
    next_edge();
    drive(1'b0, 32'h8000_0001, 1'b1, 1'b0);
    check("midrst post tag", 32'(a_tag), 32'd0);
    next_edge();

`ifdef BSG_RR_ARB_STARVE_CHK_EN
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h3, 1'b1, 1'b1);
      check($sformatf("starve cyc%0d", i), 32'(c_st), 32'(i >= 5));
      next_edge();
    end
`endif

    // Randomized run against the model for both configurations.
    do_reset();
    m_reset();
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 5))
        0:       q = 32'h0;
        1:       q = 32'hFFFF_FFFF;
        2:       q = one << $urandom_range(0, 31);
        default: q = $urandom & $urandom & $urandom;
      endcase
      e = ($urandom_range(0, 4) != 0);
      y = $urandom_range(0, 1) && e && (q != 0);
      drive(r, q, e, y);
      for (int m = 0; m < 2; m++) begin
        w  = (r || q == 0) ? 0 : m_win(m, q);
        es = (r || q == 0) ? 32'h0 : (one << w);
        if (m == 0) begin
          check("rnd a v_o", 32'(a_v), 32'(!r && q != 0));
          check("rnd a tag_o", 32'(a_tag), 32'(w));
          check("rnd a grants", a_gnt, e ? es : 32'h0);
        end else begin
          check("rnd b v_o", 32'(b_v), 32'(!r && q != 0));
          check("rnd b tag_o", 32'(b_tag), 32'(w));
          check("rnd b sel", b_sel, es);
        end
        m_step(m, r, q, e, y);
      end
`ifndef BSG_RR_ARB_STARVE_CHK_EN
      if (c % 50 == 0) check("rnd starve_o", 32'(a_st | c_st), 32'h0);
`endif
      next_edge();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
